// File: rtl/instrumentation_trip_unit.sv
// instrumentation_trip_unit
// Per-channel trip generator: compares each channel's sensor value against its
// setpoint, debounces the comparison over consecutive valid samples, and
// combines the result with the channel mode into a fail-safe trip output.
//
// Optional feature macro: INSTR_TRIP_LATCH_EN
//   defined   - an operate-mode trip is held until an explicit trip_reset,
//               honoured only once the last valid sample no longer trips.
//   undefined - trip_reset is ignored; in operate mode the trip clears on the
//               first valid non-tripping sample (trip follows the debounce).
module instrumentation_trip_unit #(
    parameter int                   NChannels      = 3,
    parameter int                   Width          = 32,
    parameter int                   DebounceCycles = 2,
    parameter logic [NChannels-1:0] SignedMask     = NChannels'(3'b100),
    parameter logic [NChannels-1:0] LowTripMask    = NChannels'(3'b100)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic [NChannels*Width-1:0] vals,
    input  logic [NChannels*Width-1:0] setpoints,
    input  logic [2*NChannels-1:0]     mode,
    input  logic [NChannels-1:0]       trip_reset,
    output logic [NChannels-1:0]       sensor_trip,
    output logic [NChannels-1:0]       trip
);

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'd0,
        MODE_OPERATE  = 2'd1,
        MODE_MANUAL   = 2'd2,
        MODE_RESERVED = 2'd3
    } mode_e;

    localparam int              CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] DebMax = CntW'(DebounceCycles);

`ifndef INSTR_TRIP_LATCH_EN
    // Operator reset has no function when trips are not latched.
    logic unused_trip_reset;
    assign unused_trip_reset = ^trip_reset;
`endif

    for (genvar ch = 0; ch < NChannels; ch++) begin : g_ch
        logic [Width-1:0] v;
        logic [Width-1:0] sp;
        mode_e            ch_mode;
        logic             raw;
        logic [CntW-1:0]  cnt_q;
        logic [CntW-1:0]  cnt_d;
        logic             deb;
        logic             trip_q;
        logic             trip_d;
        logic             sensor_q;

        assign v       = vals[ch*Width +: Width];
        assign sp      = setpoints[ch*Width +: Width];
        assign ch_mode = mode_e'(mode[2*ch +: 2]);

        // Raw comparison: signedness and trip direction fixed per channel; equality never trips.
        always_comb begin
            raw = 1'b0;
            if (SignedMask[ch]) begin
                raw = LowTripMask[ch] ? ($signed(v) < $signed(sp)) : ($signed(v) > $signed(sp));
            end else begin
                raw = LowTripMask[ch] ? (v < sp) : (v > sp);
            end
        end

        // Next debounce count and trip state, highest-priority mode rule last.
        always_comb begin
            // NOTE: every output gets a default first so no path leaves a latch behind.
            cnt_d  = cnt_q;
            trip_d = trip_q;
            if (sample_valid) begin
                if (raw) begin
                    cnt_d = (cnt_q == DebMax) ? cnt_q : cnt_q + CntW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            // Debounce sees the count including this cycle's update.
            deb = (cnt_d == DebMax);
            case (ch_mode)
                MODE_BYPASS: begin
                    trip_d = 1'b0;
                    cnt_d  = '0;
                end
                MODE_OPERATE: begin
                    if (deb) begin
                        trip_d = 1'b1;
`ifdef INSTR_TRIP_LATCH_EN
                    end else if (trip_reset[ch] && trip_q && !sensor_q) begin
                        // sensor_q is the raw result of the last valid sample.
                        trip_d = 1'b0;
`else
                    end else if (sample_valid && !raw) begin
                        trip_d = 1'b0;
`endif
                    end
                end
                // Manual trip; reserved is treated the same way (fail-safe).
                default: trip_d = 1'b1;
            endcase
        end

        // Channel state registers; reset discards any partial debounce count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q    <= '0;
                trip_q   <= 1'b0;
                sensor_q <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
                cnt_q  <= cnt_d;
                trip_q <= trip_d;
                if (sample_valid) begin
                    sensor_q <= raw;
                end
            end
        end

        assign sensor_trip[ch] = sensor_q;
        assign trip[ch]        = trip_q;
    end

endmodule
